// File: rtl/fq_pkg.sv
// Shared constants and the entry layout for the fetch queue.
package fq_pkg;

    localparam int FQ_DEPTH  = 4;
    localparam int INSTR_W   = 32;
    localparam int ADDR_W    = 32;
    localparam int ENTRY_W   = 1 + ADDR_W + ADDR_W + INSTR_W;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // MSB-first layout: {adel, pcplus, pc, instr}
    typedef struct packed {
        logic              adel;
        logic [ADDR_W-1:0] pcplus;
        logic [ADDR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;

    function automatic fq_entry_t make_entry(input logic [INSTR_W-1:0] instr,
                                             input logic [ADDR_W-1:0]  pc,
                                             input logic [ADDR_W-1:0]  pcplus);
        fq_entry_t e;
        e.instr  = instr;
        e.pc     = pc;
        e.pcplus = pcplus;
        e.adel   = (pc[1:0] != 2'b00);
        return e;
    endfunction

endpackage

// File: rtl/fq_if.sv
// Fetch-side and decode-side handshake bundle of the fetch queue.
interface fq_if;
    import fq_pkg::*;

    logic               In_Valid;
    logic               In_Ready;
    logic [INSTR_W-1:0] In_Instr;
    logic [ADDR_W-1:0]  In_PC;
    logic [ADDR_W-1:0]  In_PCPlus;
    logic               Out_Valid;
    logic               Out_Ready;
    logic [INSTR_W-1:0] Out_Instr;
    logic [ADDR_W-1:0]  Out_PC;
    logic [ADDR_W-1:0]  Out_PCPlus;
    logic               Out_AdEL;

    // slave is the queue; master is the fetch/decode side around it
    modport slave (
        input  In_Valid, In_Instr, In_PC, In_PCPlus, Out_Ready,
        output In_Ready, Out_Valid, Out_Instr, Out_PC, Out_PCPlus, Out_AdEL
    );

    modport master (
        output In_Valid, In_Instr, In_PC, In_PCPlus, Out_Ready,
        input  In_Ready, Out_Valid, Out_Instr, Out_PC, Out_PCPlus, Out_AdEL
    );

endinterface

// File: rtl/fq_storage.sv
// Entry array: one synchronous write port, one asynchronous read port.
module fq_storage
    import fq_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic [PTR_W-1:0]   raddr,
    output logic [ENTRY_W-1:0] rdata
);

    // Contents are don't-care until written, so no reset here.
    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order fetch-to-decode buffer with valid/ready on both sides and redirect flush.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Flush,
    fq_if.slave          q,
    output logic [PTR_W:0] Count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             in_ready, out_valid, push, pop;
    fq_entry_t        wr_entry, rd_entry;

    // Handshake flags come only from registered occupancy.
    assign in_ready  = (count_q != (PTR_W+1)'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = q.In_Valid && in_ready && !Flush;
    assign pop       = out_valid && q.Out_Ready && !Flush;

    assign wr_entry = make_entry(q.In_Instr, q.In_PC, q.In_PCPlus);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
            else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_storage #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_storage (
        .clk   (Clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // Empty queue presents a nop with zeroed metadata.
    assign q.In_Ready   = in_ready;
    assign q.Out_Valid  = out_valid;
    assign q.Out_Instr  = out_valid ? rd_entry.instr  : NOP_INSTR;
    assign q.Out_PC     = out_valid ? rd_entry.pc     : '0;
    assign q.Out_PCPlus = out_valid ? rd_entry.pcplus : '0;
    assign q.Out_AdEL   = out_valid & rd_entry.adel;
    assign Count        = count_q;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small in-order instruction buffer between the fetch stage (PC/IFU) and decode.
- Decouples fetch from decode stalls using a valid/ready handshake on both sides.
- Each entry captures the fetched instruction, its PC, PC+4 and an alignment-fault flag.
- A redirect from branch or jump resolution flushes it.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- PTR_W, 2, log2(DEPTH); pointer width.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset; asynchronous, active-low. Rst=0 clears all state immediately.
- Flush  in  1  synchronous redirect; discards all buffered and incoming entries.
- In_Valid  in  1  fetch presents a valid entry.
- In_Ready  out  1  queue can accept an entry this cycle.
- In_Instr  in  32  fetched instruction word.
- In_PC  in  32  address of In_Instr.
- In_PCPlus  in  32  In_PC+4 from fetch.
- Out_Valid  out  1  head entry is valid.
- Out_Ready  in  1  decode consumes the head this cycle.
- Out_Instr  out  32  head instruction; 32'h0000_0000 (nop) when Out_Valid=0.
- Out_PC  out  32  head PC; 0 when empty.
- Out_PCPlus  out  32  head PC+4; 0 when empty.
- Out_AdEL  out  1  head PC was misaligned (PC[1:0]!=0); 0 when empty.
- Count  out  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (Rst=0, async): read pointer, write pointer and Count go to 0. Out_Valid=0, Out_Instr/Out_PC/Out_PCPlus=0, Out_AdEL=0, In_Ready=1. Entry storage contents need not be cleared.
- Derived signals: In_Ready = (Count != DEPTH); Out_Valid = (Count != 0). Both are combinational from registered state only; neither depends on In_Valid or Out_Ready (no combinational path from input to output).
- Push: In_Valid & In_Ready & !Flush. Writes {In_Instr, In_PC, In_PCPlus, (In_PC[1:0]!=0)} at the write pointer; write pointer increments modulo DEPTH.
- Pop: Out_Valid & Out_Ready & !Flush. Read pointer increments modulo DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: an entry pushed into an empty queue appears at Out_* in the next cycle (one cycle). There is no same-cycle bypass.
- Full: In_Ready=0, so no push even if a pop occurs in the same cycle. The freed slot is visible next cycle.
- Empty: Out_Valid=0 and the outputs show the nop/zero values. Out_Ready is ignored.
- Wrap-around: pointers wrap at DEPTH. Count disambiguates full from empty.
- Flush (highest priority after reset): pointers and Count go to 0 on the next edge. A push or pop in the same cycle is suppressed. Out_Valid=0 from the following cycle.
- Data ordering: strict FIFO. Out_* always reflects the entry at the read pointer.
- Out_AdEL is carried only. The queue does not block or alter misaligned entries.
- Rst asserted mid-operation: all entries are lost asynchronously. The first push after Rst deasserts is accepted on the next edge.

Decomposition:
- Shared package fq_pkg holds:
  - DEPTH default.
  - NOP_INSTR = 32'h0000_0000.
  - Entry field widths: INSTR_W=32, ADDR_W=32.
  - ENTRY_W = 97 ({adel, pcplus, pc, instr}).
- One natural sub-module, fq_storage: a DEPTH x ENTRY_W register array with one synchronous write port and an asynchronous read port, indexed by pointer. Pointer, count and handshake control stay in fetch_queue.

Test Plan:
- Reset: hold Rst=0 with In_Valid=1 -> Count=0, Out_Valid=0, Out_Instr=0, In_Ready=1. Release Rst, push In_Instr=32'h2408_0005, In_PC=32'h0000_3000, In_PCPlus=32'h0000_3004 -> next cycle Out_Valid=1, Out_Instr=32'h2408_0005, Out_PC=32'h3000, Count=1.
- Fill and order: Out_Ready=0, push PCs 0x3000, 0x3004, 0x3008, 0x300C -> Count=4, In_Ready=0. A fifth push at 0x3010 is not accepted. Then Out_Ready=1 -> outputs PCs 0x3000..0x300C in order over 4 cycles, then Out_Valid=0.
- Simultaneous push/pop: Count=2, push and pop every cycle for 10 cycles -> Count stays 2. Pointers wrap past 3. Output PCs stay sequential with no gaps or duplicates.
- Full with pop: Count=4, In_Valid=1, Out_Ready=1 -> push rejected that cycle, Count=3. The next cycle accepts the push and Count stays 3 with Out_Ready still 1.
- Flush: Count=3, assert Flush with In_Valid=1 and Out_Ready=1 -> next cycle Count=0, Out_Valid=0, and the incoming entry is not stored. Then push In_PC=0x3100 -> it is the head next cycle.
- Misaligned: push In_PC=32'h0000_3002 -> Out_AdEL=1 with Out_PC=0x3002. The following aligned entry at 0x3004 shows Out_AdEL=0.
